multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Main control FSM for the multi-cycle MIPS datapath; drives ALUOp_o to ALU_Ctrl and all datapath enables/selects.
//  Sequences FETCH/DECODE/EXEC/MEM/WB from opcode_i (IR[31:26]) and waits on a single-port memory ready handshake.
//  Retires one instruction per pass; flags illegal opcodes and memory stalls that exceed a limit.
// PARAMETERS
//  OP_RTYPE 6'b000000 R-type; OP_ADDI 6'b001000; OP_LW 6'b101100; OP_SW 6'b101101
//  OP_BEQ 6'b001010; OP_BNE 6'b001011; OP_J 6'b000010
//  STALL_MAX 15  max cycles a memory state waits for mem_ready_i (>=2)
// PORTS
//  clk_i  in 1  clock, rising edge
//  rst_i  in 1  asynchronous, active-high reset
//  opcode_i  in 6  IR[31:26]; stable from DECODE until next IR write
//  mem_ready_i  in 1  memory completes the current read/write this cycle
//  ALUOp_o  out 2  00 R-type(funct), 01 add, 10 sub(beq), 11 sub(bne)
//  ALUSrcA_o  out 1  0 PC, 1 rs
//  ALUSrcB_o  out 2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  IorD_o  out 1  memory address: 0 PC, 1 ALUOut
//  mem_read_o / mem_write_o  out 1 each  memory strobes
//  ir_write_o  out 1  IR load enable
//  reg_write_o  out 1  register-file write; reg_dst_o out 1 (1 rd, 0 rt); mem_to_reg_o out 1 (1 MDR)
//  pc_write_o  out 1  unconditional PC write; pc_write_cond_o out 1 branch PC write
//  branch_ne_o  out 1  1 = take branch on !zero (bne); pc_src_o out 2  00 ALU, 01 ALUOut, 10 jump target
//  state_o  out 4  current state; retire_o out 1  last cycle of an instruction
//  illegal_o  out 1  one-cycle pulse on unknown opcode; bus_err_o out 1  one-cycle pulse on stall timeout
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MEM_ADDR=2 MEM_RD=3 MEM_WB=4 MEM_WR=5 R_EXEC=6 R_WB=7 I_EXEC=8 I_WB=9 BRANCH=10 JUMP=11.
//  Reset: state=FETCH, stall counter=0; every output 0 while rst_i high (incl. ALUOp_o, state_o).
//  Outputs are Moore-decoded from state; default ALUOp_o=01, all other outputs 0.
//  FETCH: mem_read=1, IorD=0, SrcA=0, SrcB=01, ALUOp=01; ir_write=pc_write=mem_ready_i; -> DECODE when ready, else hold.
//  DECODE: SrcA=0, SrcB=11, ALUOp=01 (branch target to ALUOut). Next by opcode:
//   LW/SW->MEM_ADDR, RTYPE->R_EXEC, ADDI->I_EXEC, BEQ/BNE->BRANCH, J->JUMP, other->FETCH + illegal_o=1.
//  MEM_ADDR: SrcA=1, SrcB=10, ALUOp=01; -> MEM_RD (LW) or MEM_WR (SW).
//  MEM_RD: IorD=1, mem_read=1; hold until mem_ready_i, then -> MEM_WB.
//  MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, retire=1; -> FETCH.
//  MEM_WR: IorD=1, mem_write=1; retire=mem_ready_i; -> FETCH when ready, else hold.
//  R_EXEC: SrcA=1, SrcB=00, ALUOp=00 -> R_WB: reg_write=1, reg_dst=1, retire=1 -> FETCH.
//  I_EXEC: SrcA=1, SrcB=10, ALUOp=01 -> I_WB: reg_write=1, reg_dst=0, retire=1 -> FETCH.
//  BRANCH: SrcA=1, SrcB=00, ALUOp=10 (BEQ) / 11 (BNE), branch_ne=(opcode==OP_BNE), pc_write_cond=1, pc_src=01, retire=1 -> FETCH.
//  JUMP: pc_write=1, pc_src=10, retire=1 -> FETCH.
//  Zero-wait latency: R/ADDI/SW 4, LW 5, BEQ/BNE/J 3 cycles.
//  Stall counter (width $clog2(STALL_MAX+1)): counts cycles in FETCH/MEM_RD/MEM_WR with mem_ready_i=0;
//   clears on any state change or on ready. At count==STALL_MAX-1 with ready still 0: bus_err_o=1 that cycle,
//   next state FETCH, counter cleared, no retire, no ir/pc write. In FETCH this restarts fetch at the same PC.
//  mem_ready_i outside memory states is ignored. rst_i mid-instruction: immediate return to FETCH, strobes drop asynchronously.
// TESTING
//  R-type, mem_ready_i=1: states 0,1,6,7,0; ALUOp_o=00 in R_EXEC; reg_write_o=1, reg_dst_o=1 in R_WB; retire_o once.
//  LW, ready low 3 cycles in MEM_RD: MEM_RD held 4 cycles, total 8 cycles, mem_to_reg_o=1 only in MEM_WB.
//  BNE: BRANCH has ALUOp_o=11, branch_ne_o=1, pc_write_cond_o=1, pc_src_o=01; BEQ gives ALUOp_o=10, branch_ne_o=0.
//  opcode 6'b111111: DECODE -> FETCH, illegal_o exactly 1 cycle, retire_o never asserted.
//  STALL_MAX=15, ready held 0 in FETCH: bus_err_o pulses on 15th cycle, state stays 0, ir_write_o never 1.
//  rst_i pulsed mid-MEM_WR: mem_write_o falls before next clk edge, state_o=0, next instruction fetches cleanly.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for the multi-cycle MIPS datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB, waits on memory ready, flags illegal opcodes and stall timeouts.
module multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE  = 6'b000000,
  parameter logic [5:0] OP_ADDI   = 6'b001000,
  parameter logic [5:0] OP_LW     = 6'b101100,
  parameter logic [5:0] OP_SW     = 6'b101101,
  parameter logic [5:0] OP_BEQ    = 6'b001010,
  parameter logic [5:0] OP_BNE    = 6'b001011,
  parameter logic [5:0] OP_J      = 6'b000010,
  parameter int         STALL_MAX = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output logic [1:0] ALUOp_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic       IorD_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       branch_ne_o,
  output logic [1:0] pc_src_o,
  output logic [3:0] state_o,
  output logic       retire_o,
  output logic       illegal_o,
  output logic       bus_err_o
);
  localparam int CW = $clog2(STALL_MAX + 1);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3, MEM_WB = 4'd4, MEM_WR = 4'd5,
    R_EXEC = 4'd6, R_WB = 4'd7, I_EXEC = 4'd8, I_WB = 4'd9, BRANCH = 4'd10, JUMP = 4'd11
  } state_t;
  state_t state, next_state;
  logic [CW-1:0] cnt;
  logic mem_st, timeout;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= (!mem_st || mem_ready_i || timeout || next_state != state) ? '0 : cnt + 1'b1;
    end
  always_comb begin
    mem_st          = state inside {FETCH, MEM_RD, MEM_WR};
    timeout         = mem_st && !mem_ready_i && cnt == CW'(STALL_MAX - 1);
    next_state      = state;
    ALUOp_o         = 2'b01;
    ALUSrcA_o       = 1'b0;
    ALUSrcB_o       = 2'b00;
    IorD_o          = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    reg_write_o     = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    branch_ne_o     = 1'b0;
    pc_src_o        = 2'b00;
    retire_o        = 1'b0;
    illegal_o       = 1'b0;
    case (state)
      FETCH: begin
        mem_read_o = 1'b1;
        ALUSrcB_o  = 2'b01;
        ir_write_o = mem_ready_i;
        pc_write_o = mem_ready_i;
        next_state = mem_ready_i ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB_o = 2'b11;
        if (opcode_i == OP_LW || opcode_i == OP_SW) next_state = MEM_ADDR;
        else if (opcode_i == OP_RTYPE) next_state = R_EXEC;
        else if (opcode_i == OP_ADDI) next_state = I_EXEC;
        else if (opcode_i == OP_BEQ || opcode_i == OP_BNE) next_state = BRANCH;
        else if (opcode_i == OP_J) next_state = JUMP;
        else begin
          next_state = FETCH;
          illegal_o  = 1'b1;
        end
      end
      MEM_ADDR: begin
        ALUSrcA_o  = 1'b1;
        ALUSrcB_o  = 2'b10;
        next_state = (opcode_i == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        IorD_o     = 1'b1;
        mem_read_o = 1'b1;
        next_state = mem_ready_i ? MEM_WB : MEM_RD;
      end
      MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        retire_o     = 1'b1;
        next_state   = FETCH;
      end
      MEM_WR: begin
        IorD_o      = 1'b1;
        mem_write_o = 1'b1;
        retire_o    = mem_ready_i;
        next_state  = mem_ready_i ? FETCH : MEM_WR;
      end
      R_EXEC: begin
        ALUSrcA_o  = 1'b1;
        ALUOp_o    = 2'b00;
        next_state = R_WB;
      end
      R_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
        retire_o    = 1'b1;
        next_state  = FETCH;
      end
      I_EXEC: begin
        ALUSrcA_o  = 1'b1;
        ALUSrcB_o  = 2'b10;
        next_state = I_WB;
      end
      I_WB: begin
        reg_write_o = 1'b1;
        retire_o    = 1'b1;
        next_state  = FETCH;
      end
      BRANCH: begin
        ALUSrcA_o       = 1'b1;
        branch_ne_o     = opcode_i == OP_BNE;
        ALUOp_o         = branch_ne_o ? 2'b11 : 2'b10;
        pc_write_cond_o = 1'b1;
        pc_src_o        = 2'b01;
        retire_o        = 1'b1;
        next_state      = FETCH;
      end
      JUMP: begin
        pc_write_o = 1'b1;
        pc_src_o   = 2'b10;
        retire_o   = 1'b1;
        next_state = FETCH;
      end
      default: next_state = FETCH;
    endcase
    // a timeout abandons the access: restart at FETCH with no retire or IR/PC update
    if (timeout) begin
      next_state = FETCH;
      retire_o   = 1'b0;
      ir_write_o = 1'b0;
      pc_write_o = 1'b0;
    end
    bus_err_o = timeout;
    state_o   = state;
    // reset forces every output low combinationally, not only after the next edge
    if (rst_i) begin
      {ALUOp_o, ALUSrcA_o, ALUSrcB_o, IorD_o, mem_read_o, mem_write_o, ir_write_o} = '0;
      {reg_write_o, reg_dst_o, mem_to_reg_o, pc_write_o, pc_write_cond_o} = '0;
      {branch_ne_o, pc_src_o, state_o, retire_o, illegal_o, bus_err_o} = '0;
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed vectors with hand-computed expectations for multicycle_ctrl.
module tb_multicycle_ctrl;
  logic clk_i = 1'b0, rst_i = 1'b1, mem_ready_i = 1'b0;
  logic [5:0] opcode_i = 6'd0;
  logic [1:0] ALUOp_o, ALUSrcB_o, pc_src_o;
  logic [3:0] state_o;
  logic ALUSrcA_o, IorD_o, mem_read_o, mem_write_o, ir_write_o, reg_write_o, reg_dst_o;
  logic mem_to_reg_o, pc_write_o, pc_write_cond_o, branch_ne_o, retire_o, illegal_o, bus_err_o;
  int runs = 0, fails = 0;

  multicycle_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .mem_ready_i(mem_ready_i),
    .ALUOp_o(ALUOp_o), .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .IorD_o(IorD_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .ir_write_o(ir_write_o),
    .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
    .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o), .branch_ne_o(branch_ne_o),
    .pc_src_o(pc_src_o), .state_o(state_o), .retire_o(retire_o), .illegal_o(illegal_o),
    .bus_err_o(bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    runs++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_state", state_o, 0);
    chk("rst_aluop", ALUOp_o, 0);
    chk("rst_memread", mem_read_o, 0);
    #10 rst_i = 1'b0;
    #1;
    // R-type, zero wait: 0,1,6,7,0
    mem_ready_i = 1'b1;
    opcode_i = 6'b000000;
    #1;
    chk("r_fetch_state", state_o, 0);
    chk("r_fetch_aluop", ALUOp_o, 1);
    chk("r_fetch_srcb", ALUSrcB_o, 1);
    chk("r_fetch_irw", ir_write_o, 1);
    tick;
    chk("r_dec_state", state_o, 1);
    chk("r_dec_srcb", ALUSrcB_o, 3);
    tick;
    chk("r_exec_state", state_o, 6);
    chk("r_exec_aluop", ALUOp_o, 0);
    chk("r_exec_srca", ALUSrcA_o, 1);
    chk("r_exec_retire", retire_o, 0);
    tick;
    chk("r_wb_state", state_o, 7);
    chk("r_wb_regw", reg_write_o, 1);
    chk("r_wb_regdst", reg_dst_o, 1);
    chk("r_wb_retire", retire_o, 1);
    tick;
    chk("r_done_state", state_o, 0);
    // LW with three wait cycles in MEM_RD
    opcode_i = 6'b101100;
    tick;
    tick;
    chk("lw_addr_state", state_o, 2);
    chk("lw_addr_srcb", ALUSrcB_o, 2);
    mem_ready_i = 1'b0;
    tick;
    for (int i = 0; i < 3; i++) begin
      chk("lw_rd_state", state_o, 3);
      chk("lw_rd_iord", IorD_o, 1);
      chk("lw_rd_mtr", mem_to_reg_o, 0);
      tick;
    end
    mem_ready_i = 1'b1;
    #1;
    chk("lw_rd4_state", state_o, 3);
    tick;
    chk("lw_wb_state", state_o, 4);
    chk("lw_wb_mtr", mem_to_reg_o, 1);
    chk("lw_wb_retire", retire_o, 1);
    tick;
    chk("lw_done_state", state_o, 0);
    chk("lw_done_mtr", mem_to_reg_o, 0);
    // BNE then BEQ
    opcode_i = 6'b001011;
    tick;
    tick;
    chk("bne_state", state_o, 10);
    chk("bne_aluop", ALUOp_o, 3);
    chk("bne_ne", branch_ne_o, 1);
    chk("bne_pwc", pc_write_cond_o, 1);
    chk("bne_pcsrc", pc_src_o, 1);
    opcode_i = 6'b001010;
    tick;
    tick;
    tick;
    chk("beq_state", state_o, 10);
    chk("beq_aluop", ALUOp_o, 2);
    chk("beq_ne", branch_ne_o, 0);
    // J
    opcode_i = 6'b000010;
    tick;
    tick;
    tick;
    chk("j_state", state_o, 11);
    chk("j_pcw", pc_write_o, 1);
    chk("j_pcsrc", pc_src_o, 2);
    tick;
    // illegal opcode
    opcode_i = 6'b111111;
    tick;
    chk("ill_dec_state", state_o, 1);
    chk("ill_pulse", illegal_o, 1);
    chk("ill_retire", retire_o, 0);
    tick;
    chk("ill_back_state", state_o, 0);
    chk("ill_drop", illegal_o, 0);
    // fetch stall timeout on the 15th waiting cycle
    mem_ready_i = 1'b0;
    #1;
    for (int i = 1; i <= 15; i++) begin
      chk("stall_state", state_o, 0);
      chk("stall_irw", ir_write_o, 0);
      chk("stall_buserr", bus_err_o, i == 15);
      tick;
    end
    chk("stall_after_buserr", bus_err_o, 0);
    chk("stall_after_state", state_o, 0);
    // SW interrupted by reset while waiting in MEM_WR
    mem_ready_i = 1'b1;
    opcode_i = 6'b101101;
    #1;
    chk("sw_fetch_irw", ir_write_o, 1);
    tick;
    tick;
    mem_ready_i = 1'b0;
    tick;
    chk("sw_wr_state", state_o, 5);
    chk("sw_wr_memw", mem_write_o, 1);
    chk("sw_wr_retire", retire_o, 0);
    rst_i = 1'b1;
    #1;
    chk("sw_rst_memw", mem_write_o, 0);
    chk("sw_rst_state", state_o, 0);
    #1 rst_i = 1'b0;
    mem_ready_i = 1'b1;
    opcode_i = 6'b000000;
    #1;
    chk("post_rst_memread", mem_read_o, 1);
    chk("post_rst_irw", ir_write_o, 1);
    tick;
    chk("post_rst_decode", state_o, 1);
    $display("[TB] %0d tests run, %0d failed", runs, fails);
    $finish;
  end
endmodule
